mul_job_sequencer: RTL and testbench

Bus-master sequencer that sits directly upstream of the memory-mapped multiply/popcount peripheral.
- Accepts operand pairs from a valid/ready job stream into a small FIFO.
- Drives the peripheral's address/strobe bus through the full sequence: write A1, write A2, start, poll status, read W, read ones-count.
- Emits each result on a valid/ready result stream, so software or a test harness never hand-sequences the strobes.

---
 rtl/mul_seq_pkg.sv | 37 +++
 rtl/mul_job_sequencer_if.sv | 31 +++
 rtl/mul_bus_access.sv | 83 ++++++++
 rtl/mul_job_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mul_job_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_seq_pkg.sv
// Shared constants and types for the multiply/popcount job sequencer: peripheral register map,
// status bit positions, FSM states and bus access descriptors.
package mul_seq_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h037F;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_ONES = 16'h0398;

  localparam int unsigned STAT_READY = 1;
  localparam int unsigned STAT_VALID = 0;

  typedef enum logic [3:0] {
    StIdle, StWrA1, StWrA2, StWrStart, StWait,
    StRdStatus, StRdW0, StRdW1, StRdOnes, StPush
  } seq_state_t;

  typedef enum logic {ACC_RD, ACC_WR} acc_kind_t;

  typedef enum logic [1:0] {PhIdle, PhSetup, PhStrobe, PhHold} acc_phase_t;

  typedef struct packed {
    acc_kind_t   kind;
    logic [15:0] addr;
    logic [31:0] wdata;
  } acc_req_t;

  function automatic acc_req_t mk_req(acc_kind_t kind, logic [15:0] addr, logic [31:0] wdata);
    acc_req_t r;
    r.kind  = kind;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/mul_job_sequencer_if.sv
// Job stream, peripheral bus and result stream of the sequencer; master is the sequencer side,
// slave is the side of the job source, peripheral and result consumer.
interface mul_job_sequencer_if;
  logic        job_valid;
  logic        job_ready;
  logic [23:0] job_a1;
  logic [23:0] job_a2;
  logic [15:0] m_address;
  logic        m_wr;
  logic        m_rd;
  logic [31:0] m_data_out;
  logic [31:0] m_data_in;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_w;
  logic [23:0] res_ones;
  logic        res_ovf;
  logic        res_timeout;

  modport master (
    input  job_valid, job_a1, job_a2, m_data_in, res_ready,
    output job_ready, m_address, m_wr, m_rd, m_data_out,
    output res_valid, res_w, res_ones, res_ovf, res_timeout
  );

  modport slave (
    output job_valid, job_a1, job_a2, m_data_in, res_ready,
    input  job_ready, m_address, m_wr, m_rd, m_data_out,
    input  res_valid, res_w, res_ones, res_ovf, res_timeout
  );
endinterface

// File: rtl/mul_bus_access.sv
// Single peripheral access engine: SETUP (1 cycle), STROBE (STROBE_CYCLES), HOLD (1 cycle).
// done_o is high during HOLD; read data is captured at the end of the last strobe cycle.
module mul_bus_access
  import mul_seq_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start_i,
  input  acc_kind_t   kind_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [15:0] m_address_o,
  output logic        m_wr_o,
  output logic        m_rd_o,
  output logic [31:0] m_data_out_o,
  input  logic [31:0] m_data_in_i
);

  localparam int unsigned CntW = $clog2(STROBE_CYCLES + 1);

  acc_phase_t        phase_q;
  acc_kind_t         kind_q;
  logic [CntW-1:0]   cnt_q;
  logic [15:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              wr_q;
  logic              rd_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase_q <= PhIdle;
      kind_q  <= ACC_RD;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      case (phase_q)
        PhIdle: begin
          if (start_i) begin
            phase_q <= PhSetup;
            kind_q  <= kind_i;
            addr_q  <= addr_i;
            wdata_q <= (kind_i == ACC_WR) ? wdata_i : 32'h0;
          end
        end
        PhSetup: begin
          phase_q <= PhStrobe;
          cnt_q   <= '0;
          wr_q    <= (kind_q == ACC_WR);
          rd_q    <= (kind_q == ACC_RD);
        end
        PhStrobe: begin
          if (cnt_q == CntW'(STROBE_CYCLES - 1)) begin
            phase_q <= PhHold;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            if (kind_q == ACC_RD) rdata_q <= m_data_in_i;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PhHold:  phase_q <= PhIdle;
        default: phase_q <= PhIdle;
      endcase
    end
  end

  assign done_o       = (phase_q == PhHold);
  assign rdata_o      = rdata_q;
  assign m_address_o  = addr_q;
  assign m_wr_o       = wr_q;
  assign m_rd_o       = rd_q;
  assign m_data_out_o = wdata_q;

endmodule

// File: rtl/mul_job_sequencer.sv
// Job sequencer: buffers operand pairs, walks the multiply peripheral through write/start/poll/read
// and returns each product and popcount on the result stream, one job in flight at a time.
module mul_job_sequencer
  import mul_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned START_WAIT    = 6,
  parameter int unsigned POLL_LIMIT    = 64
) (
  input  logic                clk,
  input  logic                n_reset,
  mul_job_sequencer_if.master bus,
  output logic                busy
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned WaitW = $clog2(START_WAIT + 1);
  localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);

  // Asserts asynchronously, releases on the second clock edge after n_reset rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  seq_state_t       state_q;
  acc_req_t         req_q;
  logic             start_q;
  logic [23:0]      a2_q;
  logic [WaitW-1:0] wait_q;
  logic [PollW-1:0] poll_q;
  logic             ovf_q;
  logic [31:0]      w_q;
  logic             res_valid_q, res_ovf_q, res_timeout_q;
  logic [31:0]      res_w_q;
  logic [23:0]      res_ones_q;
  logic             acc_done;
  logic [31:0]      acc_rdata;

  // Job FIFO: pointers carry a wrap bit; memory needs no reset since pointers define contents.
  logic [47:0]   fifo_q [FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic          full, empty, push, pop, rdy_en_q;
  logic [47:0]   head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign head  = fifo_q[rd_ptr_q[PtrW-1:0]];
  assign pop   = (state_q == StIdle) && !empty;
  assign bus.job_ready = rdy_en_q && (!full || pop);
  assign push  = bus.job_valid && bus.job_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PtrW-1:0]] <= {bus.job_a1, bus.job_a2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      req_q         <= mk_req(ACC_RD, 16'h0, 32'h0);
      start_q       <= 1'b0;
      a2_q          <= '0;
      wait_q        <= '0;
      poll_q        <= '0;
      ovf_q         <= 1'b0;
      w_q           <= '0;
      res_valid_q   <= 1'b0;
      res_w_q       <= '0;
      res_ones_q    <= '0;
      res_ovf_q     <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        StIdle: if (pop) begin
          a2_q    <= head[23:0];
          req_q   <= mk_req(ACC_WR, ADDR_A1, {8'h0, head[47:24]});
          start_q <= 1'b1;
          state_q <= StWrA1;
        end
        StWrA1: if (acc_done) begin
          req_q   <= mk_req(ACC_WR, ADDR_A2, {8'h0, a2_q});
          start_q <= 1'b1;
          state_q <= StWrA2;
        end
        StWrA2: if (acc_done) begin
          req_q   <= mk_req(ACC_WR, ADDR_CTRL, 32'h0);
          start_q <= 1'b1;
          state_q <= StWrStart;
        end
        StWrStart: if (acc_done) begin
          wait_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (wait_q == WaitW'(START_WAIT - 1)) begin
            poll_q  <= '0;
            req_q   <= mk_req(ACC_RD, ADDR_CTRL, 32'h0);
            start_q <= 1'b1;
            state_q <= StRdStatus;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StRdStatus: if (acc_done) begin
          if (acc_rdata[STAT_READY]) begin
            ovf_q   <= !acc_rdata[STAT_VALID];
            req_q   <= mk_req(ACC_RD, ADDR_W, 32'h0);
            start_q <= 1'b1;
            state_q <= StRdW0;
          end else if (poll_q == PollW'(POLL_LIMIT - 1)) begin
            res_valid_q   <= 1'b1;
            res_w_q       <= '0;
            res_ones_q    <= '0;
            res_ovf_q     <= 1'b0;
            res_timeout_q <= 1'b1;
            state_q       <= StPush;
          end else begin
            poll_q  <= poll_q + 1'b1;
            start_q <= 1'b1;
          end
        end
        // W lags one read behind, so the first read only primes it.
        StRdW0: if (acc_done) begin
          start_q <= 1'b1;
          state_q <= StRdW1;
        end
        StRdW1: if (acc_done) begin
          w_q     <= acc_rdata;
          req_q   <= mk_req(ACC_RD, ADDR_ONES, 32'h0);
          start_q <= 1'b1;
          state_q <= StRdOnes;
        end
        StRdOnes: if (acc_done) begin
          res_valid_q   <= 1'b1;
          res_w_q       <= w_q;
          res_ones_q    <= acc_rdata[23:0];
          res_ovf_q     <= ovf_q;
          res_timeout_q <= 1'b0;
          state_q       <= StPush;
        end
        StPush: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  mul_bus_access #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_access (
    .clk          (clk),
    .n_reset      (rst_n),
    .start_i      (start_q),
    .kind_i       (req_q.kind),
    .addr_i       (req_q.addr),
    .wdata_i      (req_q.wdata),
    .done_o       (acc_done),
    .rdata_o      (acc_rdata),
    .m_address_o  (bus.m_address),
    .m_wr_o       (bus.m_wr),
    .m_rd_o       (bus.m_rd),
    .m_data_out_o (bus.m_data_out),
    .m_data_in_i  (bus.m_data_in)
  );

  assign bus.res_valid   = res_valid_q;
  assign bus.res_w       = res_w_q;
  assign bus.res_ones    = res_ones_q;
  assign bus.res_ovf     = res_ovf_q;
  assign bus.res_timeout = res_timeout_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Bench for mul_job_sequencer: behavioural multiply peripheral on the bus, directed job scenarios
// and a bus protocol monitor.
module tb_mul_job_sequencer;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_job_sequencer_if bus ();

  mul_job_sequencer #(
    .FIFO_DEPTH   (4),
    .STROBE_CYCLES(2),
    .START_WAIT   (6),
    .POLL_LIMIT   (4)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus),
    .busy   (busy)
  );

  // Peripheral model: W read returns the value latched by the previous W read.
  logic [23:0] p_a1 = '0;
  logic [23:0] p_a2 = '0;
  logic [47:0] p_prod = '0;
  logic [31:0] w_pipe = '0;
  int          stat_reads = 0;
  int          w_reads = 0;
  int          ready_after = 0;
  bit          never_ready = 1'b0;
  logic [16:0] trace[$];

  always @(posedge bus.m_wr) begin
    trace.push_back({1'b1, bus.m_address});
    case (bus.m_address)
      16'h037F: p_a1 = bus.m_data_out[23:0];
      16'h0388: p_a2 = bus.m_data_out[23:0];
      16'h03A0: begin
        p_prod = {24'h0, p_a1} * {24'h0, p_a2};
        stat_reads = 0;
        w_reads = 0;
      end
      default: ;
    endcase
  end

  always @(posedge bus.m_rd) begin
    trace.push_back({1'b0, bus.m_address});
    case (bus.m_address)
      16'h03A0: begin
        stat_reads++;
        bus.m_data_in <= {30'h0, (!never_ready && stat_reads > ready_after),
                          (p_prod[47:32] == 16'h0)};
      end
      16'h0390: begin
        w_reads++;
        bus.m_data_in <= w_pipe;
        w_pipe = p_prod[31:0];
      end
      16'h0398: bus.m_data_in <= {8'h0, 24'($countones(p_prod[31:0]))};
      default:  bus.m_data_in <= 32'hDEAD_BEEF;
    endcase
  end

  // Protocol monitor: strobes exclusive, address frozen from SETUP through HOLD.
  int          proto_err = 0;
  logic [15:0] addr_prev = '0;
  logic        strb_prev = 1'b0;
  logic        rst_prev = 1'b0;
  always @(negedge clk) begin
    if (n_reset && rst_prev) begin
      if (bus.m_rd && bus.m_wr) proto_err++;
      if ((bus.m_rd || bus.m_wr || strb_prev) && bus.m_address != addr_prev) proto_err++;
    end
    addr_prev = bus.m_address;
    strb_prev = bus.m_rd || bus.m_wr;
    rst_prev  = n_reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [23:0] a1, input logic [23:0] a2);
    int n = 0;
    bus.job_valid = 1'b1;
    bus.job_a1 = a1;
    bus.job_a2 = a2;
    while (!bus.job_ready && n < 300) begin
      tick();
      n++;
    end
    if (!bus.job_ready) begin
      checks++; errors++;
      $display("FAIL push_wait job_ready got 0 want 1 within 300 cycles");
    end
    tick();
    bus.job_valid = 1'b0;
  endtask

  task automatic get_result(output logic [31:0] w, output logic [23:0] ones,
                            output logic ovf, output logic to);
    int n = 0;
    while (!bus.res_valid && n < 3000) begin
      tick();
      n++;
    end
    if (!bus.res_valid) begin
      checks++; errors++;
      $display("FAIL result_wait res_valid got 0 want 1 within 3000 cycles");
    end
    w = bus.res_w;
    ones = bus.res_ones;
    ovf = bus.res_ovf;
    to = bus.res_timeout;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.job_ready !== 1'b0) begin errors++; $display("FAIL reset_job_ready got %0b want 0", bus.job_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", bus.res_valid); end
    checks++; if ({bus.m_rd, bus.m_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {bus.m_rd, bus.m_wr}); end
    checks++; if (bus.m_address !== 16'h0) begin errors++; $display("FAIL reset_address got %h want 0000", bus.m_address); end
    n_reset = 1'b1;
    repeat (4) tick();
    checks++; if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL release_job_ready got %0b want 1", bus.job_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [31:0] w; logic [23:0] ones; logic ovf, to;
    logic [16:0] exp_tr [7];
    exp_tr = '{17'h1037F, 17'h10388, 17'h103A0, 17'h003A0, 17'h00390, 17'h00390, 17'h00398};
    trace.delete();
    bus.res_ready = 1'b1;
    push_job(24'd3, 24'd5);
    get_result(w, ones, ovf, to);
    tick();
    checks++; if (trace.size() != 7) begin errors++; $display("FAIL basic_trace_len got %0d want 7", trace.size()); end
    for (int i = 0; i < 7 && i < trace.size(); i++) begin
      checks++;
      if (trace[i] !== exp_tr[i]) begin errors++; $display("FAIL basic_trace[%0d] got %h want %h", i, trace[i], exp_tr[i]); end
    end
    checks++; if (w !== 32'h0000000F) begin errors++; $display("FAIL basic_w got %h want 0000000f", w); end
    checks++; if (ones !== 24'd4) begin errors++; $display("FAIL basic_ones got %0d want 4", ones); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b want 0", ovf); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %0b want 0", to); end
  endtask

  task automatic test_overflow();
    logic [31:0] w; logic [23:0] ones; logic ovf, to;
    ready_after = 2;
    push_job(24'hFFFFFF, 24'hFFFFFF);
    get_result(w, ones, ovf, to);
    tick();
    ready_after = 0;
    checks++; if (w !== 32'hFE000001) begin errors++; $display("FAIL ovf_w got %h want fe000001", w); end
    checks++; if (ones !== 24'd8) begin errors++; $display("FAIL ovf_ones got %0d want 8", ones); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", ovf); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ovf_timeout got %0b want 0", to); end
    checks++; if (stat_reads != 3) begin errors++; $display("FAIL ovf_polls got %0d want 3", stat_reads); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w; logic [23:0] ones; logic ovf, to;
    logic [23:0] ja1 [5];
    logic [23:0] ja2 [5];
    logic [31:0] ew [5];
    logic [23:0] eo [5];
    int acc = 0;
    bit stable;
    ja1 = '{24'd1, 24'd2, 24'h10, 24'hFFF, 24'h1000};
    ja2 = '{24'd2, 24'd3, 24'h10, 24'h1001, 24'h1000};
    ew  = '{32'd2, 32'd6, 32'h100, 32'h00FFFFFF, 32'h01000000};
    eo  = '{24'd1, 24'd2, 24'd1, 24'd24, 24'd1};
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_job(ja1[i], ja2[i]);
    checks++; if (bus.job_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %0b want 0", bus.job_ready); end
    bus.job_valid = 1'b1; bus.job_a1 = 24'd7; bus.job_a2 = 24'd7;
    repeat (6) begin
      if (bus.job_ready) acc++;
      tick();
    end
    bus.job_valid = 1'b0;
    checks++; if (acc != 0) begin errors++; $display("FAIL b2b_full_push got %0d accepted want 0", acc); end
    for (int i = 0; i < 5; i++) begin
      get_result(w, ones, ovf, to);
      repeat (3) tick();
      stable = bus.res_valid && bus.res_w == w && bus.res_ones == ones &&
               bus.res_ovf == ovf && bus.res_timeout == to;
      checks++; if (!stable) begin errors++; $display("FAIL b2b_stable[%0d] got w=%h v=%0b want w=%h v=1", i, bus.res_w, bus.res_valid, w); end
      checks++; if (w !== ew[i]) begin errors++; $display("FAIL b2b_w[%0d] got %h want %h", i, w, ew[i]); end
      checks++; if (ones !== eo[i]) begin errors++; $display("FAIL b2b_ones[%0d] got %0d want %0d", i, ones, eo[i]); end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
    end
    repeat (60) tick();
    checks++; if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got busy=%0b res_valid=%0b want 0 0", busy, bus.res_valid); end
  endtask

  task automatic test_timeout();
    logic [31:0] w; logic [23:0] ones; logic ovf, to;
    never_ready = 1'b1;
    bus.res_ready = 1'b1;
    push_job(24'd2, 24'd2);
    get_result(w, ones, ovf, to);
    tick();
    never_ready = 1'b0;
    checks++; if (stat_reads != 4) begin errors++; $display("FAIL to_polls got %0d want 4", stat_reads); end
    checks++; if (to !== 1'b1) begin errors++; $display("FAIL to_flag got %0b want 1", to); end
    checks++; if (w !== 32'h0 || ones !== 24'h0) begin errors++; $display("FAIL to_zero got w=%h ones=%0d want 0 0", w, ones); end
    push_job(24'd6, 24'd7);
    get_result(w, ones, ovf, to);
    tick();
    checks++; if (w !== 32'd42 || ones !== 24'd3) begin errors++; $display("FAIL to_next got w=%h ones=%0d want 0000002a 3", w, ones); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL to_next_flag got %0b want 0", to); end
  endtask

  task automatic test_protocol();
    logic [31:0] w; logic [23:0] ones; logic ovf, to;
    logic [23:0] a1, a2;
    logic [47:0] prod;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = 24'($urandom);
      a2 = 24'($urandom);
      prod = {24'h0, a1} * {24'h0, a2};
      push_job(a1, a2);
      get_result(w, ones, ovf, to);
      tick();
      checks++;
      if (w !== prod[31:0] || ones !== 24'($countones(prod[31:0])) || ovf !== (prod[47:32] != 0)) begin
        errors++;
        $display("FAIL rand_result[%0d] got w=%h ones=%0d ovf=%0b want w=%h ones=%0d ovf=%0b",
                 i, w, ones, ovf, prod[31:0], $countones(prod[31:0]), prod[47:32] != 0);
      end
    end
    checks++; if (proto_err != 0) begin errors++; $display("FAIL protocol got %0d violations want 0", proto_err); end
  endtask

  task automatic test_reset_midaccess();
    logic [31:0] w; logic [23:0] ones; logic ovf, to;
    int n = 0;
    bus.res_ready = 1'b0;
    push_job(24'd9, 24'd9);
    push_job(24'd4, 24'd4);
    w_reads = 0;
    while (w_reads < 2 && n < 500) begin
      tick();
      n++;
    end
    if (w_reads < 2) begin
      checks++; errors++;
      $display("FAIL midreset_wait got %0d W reads want 2 within 500 cycles", w_reads);
    end
    #2;
    n_reset = 1'b0;
    #1;
    checks++; if (bus.m_rd !== 1'b0 || bus.m_wr !== 1'b0) begin errors++; $display("FAIL midreset_strobe got rd=%0b wr=%0b want 0 0", bus.m_rd, bus.m_wr); end
    checks++; if (busy !== 1'b0 || bus.job_ready !== 1'b0) begin errors++; $display("FAIL midreset_state got busy=%0b ready=%0b want 0 0", busy, bus.job_ready); end
    repeat (3) tick();
    n_reset = 1'b1;
    repeat (4) tick();
    checks++; if (bus.job_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midreset_release got ready=%0b busy=%0b want 1 0", bus.job_ready, busy); end
    repeat (60) tick();
    checks++; if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL midreset_flushed got busy=%0b res_valid=%0b want 0 0", busy, bus.res_valid); end
    bus.res_ready = 1'b1;
    push_job(24'd3, 24'd5);
    get_result(w, ones, ovf, to);
    tick();
    checks++; if (w !== 32'hF || ones !== 24'd4) begin errors++; $display("FAIL midreset_recover got w=%h ones=%0d want 0000000f 4", w, ones); end
  endtask

  initial begin
    bus.job_valid = 1'b0;
    bus.job_a1 = '0;
    bus.job_a2 = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_protocol();
    test_reset_midaccess();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
